// File: rtl/midori_sbox_layer_ctrl.sv
// Sequencer that streams the eight byte lanes of a 3-share masked Midori state
// through one shared, pipelined TwoSboxes instance and reassembles the output shares.
module midori_sbox_layer_ctrl #(
    parameter int SBOX_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [63:0]  st1_i,
    input  logic [63:0]  st2_i,
    input  logic [63:0]  st3_i,
    input  logic         rnd_valid_i,
    input  logic [191:0] rnd_i,
    output logic         rnd_ready_o,
    output logic [7:0]   sb_in1_o,
    output logic [7:0]   sb_in2_o,
    output logic [7:0]   sb_in3_o,
    output logic [191:0] sb_r_o,
    input  logic [7:0]   sb_out1_i,
    input  logic [7:0]   sb_out2_i,
    input  logic [7:0]   sb_out3_i,
    output logic [63:0]  res1_o,
    output logic [63:0]  res2_o,
    output logic [63:0]  res3_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } tag_t;

    state_t      state;
    logic [3:0]  issue_cnt;
    logic [3:0]  cap_cnt;
    logic [63:0] sh1, sh2, sh3;
    tag_t        tag_pipe [SBOX_LATENCY];

    logic pipe_run;
    logic issue_fire;
    logic cap_fire;
    tag_t tag_in;
    tag_t tag_out;

    assign pipe_run   = (state == S_ISSUE) || (state == S_DRAIN);
    assign issue_fire = (state == S_ISSUE) && rnd_valid_i;
    assign tag_in     = '{valid: issue_fire, idx: issue_cnt[2:0]};
    assign tag_out    = tag_pipe[SBOX_LATENCY-1];
    assign cap_fire   = pipe_run && tag_out.valid;

    // The S-box pair sees data and randomness only on a real issue, so no word is wasted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rnd_ready_o = 1'b0;
        sb_in1_o    = '0;
        sb_in2_o    = '0;
        sb_in3_o    = '0;
        sb_r_o      = '0;
        if (issue_fire) begin
            rnd_ready_o = 1'b1;
            sb_in1_o    = sh1[{issue_cnt[2:0], 3'b000} +: 8];
            sb_in2_o    = sh2[{issue_cnt[2:0], 3'b000} +: 8];
            sb_in3_o    = sh3[{issue_cnt[2:0], 3'b000} +: 8];
            sb_r_o      = rnd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            sh1       <= '0;
            sh2       <= '0;
            sh3       <= '0;
            res1_o    <= '0;
            res2_o    <= '0;
            res3_o    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            // NOTE: the tag pipe is a handful of flops, not a RAM, so it is cleared to drop in-flight issues.
            for (int i = 0; i < SBOX_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let the shift and the capture below all read pre-edge values.
            if (pipe_run) begin
                tag_pipe[0] <= tag_in;
                for (int i = 1; i < SBOX_LATENCY; i++) begin
                    tag_pipe[i] <= tag_pipe[i-1];
                end
            end

            if (cap_fire) begin
                res1_o[{tag_out.idx, 3'b000} +: 8] <= sb_out1_i;
                res2_o[{tag_out.idx, 3'b000} +: 8] <= sb_out2_i;
                res3_o[{tag_out.idx, 3'b000} +: 8] <= sb_out3_i;
                cap_cnt <= cap_cnt + 4'd1;
            end

            if (issue_fire) begin
                issue_cnt <= issue_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        sh1       <= st1_i;
                        sh2       <= st2_i;
                        sh3       <= st3_i;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        busy_o    <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire && issue_cnt == 4'd7) begin
                        state <= S_DRAIN;
                    end
                end
                // Leave on the capture that completes lane 7 so done_o coincides with full results.
                S_DRAIN: begin
                    if (cap_fire && cap_cnt == 4'd7) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
